instr_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read port. Holds the PC, drives the IM word address,

---
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : Holds the PC, reads one word from the instruction memory and
//           latches it into the IR; handles PC redirects and fetch rejection.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] PC_BASE  = 32'h0000_0000,
  parameter int          IM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        fetch_err,
  output logic        busy,
  output logic [31:0] instr_cnt
);

  localparam logic [32:0] C_WIN_BYTES = 33'(4 * IM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ir_valid_q, ir_valid_d;
  logic        fetch_err_q, fetch_err_d;

  logic [31:0] w_offset;
  logic        w_bad_pc;

  // Unsigned offset: a PC below PC_BASE wraps to a huge value and is rejected.
  assign w_offset = pc_q - PC_BASE;
  assign w_bad_pc = (pc_q[1:0] != 2'b00) || ({1'b0, w_offset} >= C_WIN_BYTES);

  assign im_addr   = w_offset[11:2];
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = fetch_err_q;
  assign busy      = (state_q != IDLE);
  assign instr_cnt = cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    ir_valid_d  = 1'b0;
    fetch_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_we) begin
          pc_d = pc_next;
        end else if (fetch_req) begin
          if (w_bad_pc) fetch_err_d = 1'b1;
          else          state_d     = READ;
        end
      end
      READ: begin
        if (pc_we) begin
          pc_d    = pc_next;
          state_d = IDLE;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        // A redirect here discards the word the IM just returned.
        if (pc_we) begin
          pc_d = pc_next;
        end else begin
          ir_d       = im_dout;
          pc_d       = pc_q + 32'd4;
          cnt_d      = cnt_q + 32'd1;
          ir_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= PC_BASE;
      ir_q        <= 32'd0;
      cnt_q       <= 32'd0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      ir_valid_q  <= ir_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch_unit
// Brief   : Directed self-checking bench for instr_fetch_unit with a
//           registered-read instruction memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic        pc_we;
  logic [31:0] pc_next;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ir;
  logic        ir_valid;
  logic        fetch_err;
  logic        busy;
  logic [31:0] instr_cnt;

  logic [31:0] mem [0:1023];

  int passed;
  int total;

  instr_fetch_unit #(
    .PC_BASE  (32'h0000_0000),
    .IM_DEPTH (1024)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_req (fetch_req),
    .pc_we     (pc_we),
    .pc_next   (pc_next),
    .im_addr   (im_addr),
    .im_dout   (im_dout),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .fetch_err (fetch_err),
    .busy      (busy),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) im_dout <= mem[im_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    fetch_req = 1'b0;
    pc_we     = 1'b0;
    pc_next   = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0BAD_0000 | 32'(i);
    mem[0] = 32'h2010_0001;
    tick();
    tick();

    // Reset state
    chk("rst_pc",     pc,        32'h0);
    chk("rst_ir",     ir,        32'h0);
    chk("rst_valid",  {31'd0, ir_valid},  32'd0);
    chk("rst_err",    {31'd0, fetch_err}, 32'd0);
    chk("rst_busy",   {31'd0, busy},      32'd0);
    chk("rst_cnt",    instr_cnt, 32'h0);
    chk("rst_imaddr", {22'd0, im_addr},   32'h0);
    chk("rst_plus4",  pc_plus4,  32'h4);

    // 1: single fetch, 3-edge latency
    rst_n     = 1'b1;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("t1_busy_e0",  {31'd0, busy},     32'd1);
    chk("t1_valid_e0", {31'd0, ir_valid}, 32'd0);
    tick();
    chk("t1_valid_e1", {31'd0, ir_valid}, 32'd0);
    tick();
    chk("t1_valid_e2", {31'd0, ir_valid}, 32'd1);
    chk("t1_ir",       ir,        32'h2010_0001);
    chk("t1_pc",       pc,        32'h4);
    chk("t1_cnt",      instr_cnt, 32'd1);
    chk("t1_busy_e2",  {31'd0, busy}, 32'd0);
    tick();
    chk("t1_valid_e3", {31'd0, ir_valid}, 32'd0);

    // 2: held fetch_req, one fetch per 3 cycles
    pulse_reset();
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[4] = 32'hCAFE_0004;
    fetch_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t2_valid", {31'd0, ir_valid}, (i % 3 == 2) ? 32'd1 : 32'd0);
      if (i == 2) chk("t2_ir0", ir, 32'h11);
      if (i == 5) chk("t2_ir1", ir, 32'h22);
      if (i == 8) chk("t2_ir2", ir, 32'h33);
    end
    fetch_req = 1'b0;
    chk("t2_pc",  pc,        32'hC);
    chk("t2_cnt", instr_cnt, 32'd3);

    // 3: redirect during READ aborts the fetch
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    pc_we     = 1'b1;
    pc_next   = 32'h10;
    tick();
    pc_we = 1'b0;
    chk("t3_pc",    pc,        32'h10);
    chk("t3_busy",  {31'd0, busy}, 32'd0);
    chk("t3_valid", {31'd0, ir_valid}, 32'd0);
    tick();
    chk("t3_valid2", {31'd0, ir_valid}, 32'd0);
    chk("t3_ir",     ir,        32'h33);
    chk("t3_cnt",    instr_cnt, 32'd3);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    chk("t3_valid3", {31'd0, ir_valid}, 32'd1);
    chk("t3_ir4",    ir,        32'hCAFE_0004);
    chk("t3_pc2",    pc,        32'h14);
    chk("t3_cnt2",   instr_cnt, 32'd4);

    // 4: pc_we beats fetch_req in IDLE
    pc_we     = 1'b1;
    pc_next   = 32'h8;
    fetch_req = 1'b1;
    tick();
    pc_we = 1'b0;
    chk("t4_pc",   pc, 32'h8);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    tick();
    fetch_req = 1'b0;
    chk("t4_busy2",  {31'd0, busy}, 32'd1);
    chk("t4_imaddr", {22'd0, im_addr}, 32'd2);
    tick();
    tick();
    chk("t4_valid", {31'd0, ir_valid}, 32'd1);
    chk("t4_ir",    ir,        32'h33);
    chk("t4_pc2",   pc,        32'hC);
    chk("t4_cnt",   instr_cnt, 32'd5);

    // 5: misaligned and out-of-window rejection, last legal word
    pc_we   = 1'b1;
    pc_next = 32'h6;
    tick();
    pc_we     = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("t5_err_mis",   {31'd0, fetch_err}, 32'd1);
    chk("t5_valid_mis", {31'd0, ir_valid},  32'd0);
    chk("t5_busy_mis",  {31'd0, busy},      32'd0);
    chk("t5_ir_mis",    ir, 32'h33);
    chk("t5_pc_mis",    pc, 32'h6);
    tick();
    chk("t5_err_clr", {31'd0, fetch_err}, 32'd0);
    pc_we   = 1'b1;
    pc_next = 32'h1000;
    tick();
    pc_we     = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("t5_err_oow", {31'd0, fetch_err}, 32'd1);
    chk("t5_cnt_oow", instr_cnt, 32'd5);
    tick();
    chk("t5_err_clr2", {31'd0, fetch_err}, 32'd0);
    mem[1023] = 32'hDEAD_BEEF;
    pc_we     = 1'b1;
    pc_next   = 32'hFFC;
    tick();
    pc_we     = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("t5_err_last", {31'd0, fetch_err}, 32'd0);
    chk("t5_imaddr",   {22'd0, im_addr},   32'd1023);
    tick();
    tick();
    chk("t5_valid_last", {31'd0, ir_valid}, 32'd1);
    chk("t5_ir_last",    ir, 32'hDEAD_BEEF);
    chk("t5_pc_last",    pc, 32'h1000);
    pc_we   = 1'b1;
    pc_next = 32'hFFFF_FFFC;
    tick();
    pc_we = 1'b0;
    chk("t5_plus4_wrap", pc_plus4, 32'h0);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("t5_err_high", {31'd0, fetch_err}, 32'd1);

    // 6: asynchronous reset in CAPT
    pc_we   = 1'b1;
    pc_next = 32'h0;
    tick();
    pc_we     = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    chk("t6_busy_capt", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_pc",   pc, 32'h0);
    chk("t6_ir",   ir, 32'h0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_cnt",  instr_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("t6_valid", {31'd0, ir_valid}, 32'd0);
    tick();
    chk("t6_valid2", {31'd0, ir_valid}, 32'd0);
    chk("t6_busy2",  {31'd0, busy},     32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
